p2p_reg_slave: RTL and testbench
================================

Name: p2p_reg_slave

Overview:
AXI-Lite register responder for the p2p box: the target end of the control-plane writes and reads issued by the system AXI-Lite master. Decodes a small register map and drives the box's datapath control outputs (mode select, per-port RX block). Holds per-port RX-drop counters that can be read and cleared. All logic is in the AXI-Lite clock domain. Drop pulses arrive already synchronised to this domain.

Parameters:
NUM_CMAC_PORT, 2, number of CMAC ports; sets the block_rx and drop counter count (1..4).
VERSION, 32'h0001_0000, constant returned by the VERSION register.

Ports:
axil_aclk  in  1  AXI-Lite clock
axil_rst  in  1  synchronous reset, active-high
s_axil_awvalid  in  1  write address valid
s_axil_awaddr  in  32  write address
s_axil_awready  out  1  write address ready
s_axil_wvalid  in  1  write data valid
s_axil_wdata  in  32  write data
s_axil_wready  out  1  write data ready
s_axil_bvalid  out  1  write response valid
s_axil_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_axil_bready  in  1  write response ready
s_axil_arvalid  in  1  read address valid
s_axil_araddr  in  32  read address
s_axil_arready  out  1  read address ready
s_axil_rvalid  out  1  read data valid
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rready  in  1  read data ready
mode  out  2  datapath mode (0 pass-through, 1 hairpin, 2 loopback, 3 reserved and treated as 0 downstream)
block_rx  out  NUM_CMAC_PORT  per-port RX block enable
drop_pulse  in  NUM_CMAC_PORT  one-cycle pulse per dropped RX packet, per port

Behaviour:
- Address decode uses awaddr/araddr[11:2]. Bits [1:0] are ignored. Bits [31:12] must be 0, otherwise the address is unmapped.
- Register map:
  - 0x000 CTRL RW: [1:0] mode.
  - 0x004 BLOCK_RX RW: [NUM_CMAC_PORT-1:0].
  - 0x008 SCRATCH RW: 32 bits.
  - 0x00C VERSION RO.
  - 0x010+4p DROP_CNT[p] RO, with clear-on-write (any write data).
  - Unused bits read 0.
- Reset values: all outputs 0, except awready=1, wready=1, arready=1. All registers and counters are 0.
- Write channel FSM states: IDLE, GOT_AW, GOT_W, RESP.
  - awready is high only in IDLE or GOT_W. wready is high only in IDLE or GOT_AW.
  - AW and W may arrive in either order or in the same cycle. Each is latched independently.
  - The cycle in which the second of the pair is accepted: the register update is applied at that clock edge, and the FSM moves to RESP with bvalid=1 from the next cycle.
  - Latency: AW and W together at cycle 0 -> bvalid=1 and the new output value at cycle 1. AW at cycle 0, W at cycle 1 -> bvalid=1 at cycle 2.
  - In RESP: awready=wready=0. bvalid and bresp are held until bready. The FSM returns to IDLE the cycle after the handshake.
  - bresp: 00 for mapped RW or DROP_CNT addresses; 10 for unmapped addresses or VERSION. Writes with SLVERR change nothing.
- Read channel FSM states: IDLE, RESP.
  - On arvalid&&arready the FSM samples the register into rdata and moves to RESP (rvalid=1 from the next cycle). arready=0 in RESP.
  - rdata and rresp are held until rready. The FSM returns to IDLE the cycle after the handshake.
  - Unmapped reads return rdata=32'hDEAD_BEEF, rresp=10.
- Read and write channels are independent and may be active concurrently.
  - A read sampled in the same cycle as a write to the same register returns the pre-write value.
- Drop counters: each DROP_CNT[p] increments by 1 on drop_pulse[p] and saturates at 32'hFFFF_FFFF (no wrap).
  - If a clearing write and a pulse occur in the same cycle, the clear wins: the result is 0 and that pulse is lost.
- Reset asserted mid-transaction: the FSMs go to IDLE, any pending response is discarded, and bvalid=rvalid=0 on the next cycle.
- Input valids are ignored while axil_rst=1.

Test Plan:
- Reset, then read 0x00C -> rvalid=1 one cycle after the AR handshake, rdata=32'h0001_0000, rresp=00. Read CTRL -> 0.
- awvalid (addr 0x000) at cycle 0, wvalid (wdata 1) at cycle 1, bready=1 -> mode=1 and bvalid=1 at cycle 2, bresp=00. The next AW is accepted at cycle 3.
- AW and W together to 0x004, data 3 -> block_rx=2'b11 at cycle 1. Then write 0x008=32'hA5A5_5A5A and read it back -> 32'hA5A5_5A5A.
- Write to 0x100, then read 0x100 -> bresp=10 with no state change; rdata=32'hDEAD_BEEF, rresp=10.
- Three drop_pulse[1] pulses -> DROP_CNT[1] at 0x014 reads 3 and DROP_CNT[0] reads 0. Write 0x014 with a pulse in the same cycle -> reads 0.
- Hold bready=0 for 5 cycles after a write -> bvalid and bresp stable, awready=0. Assert axil_rst mid-hold -> bvalid=0 next cycle, registers 0.

Source files
------------

// File: rtl/p2p_reg_slave.sv
// AXI-Lite register slave for the p2p box: mode/block_rx control, scratch, version and
// per-port RX drop counters with clear-on-write.
module p2p_reg_slave #(
    parameter int unsigned NUM_CMAC_PORT = 2,
    parameter logic [31:0] VERSION       = 32'h0001_0000
) (
    input  logic                     axil_aclk,
    input  logic                     axil_rst,
    input  logic                     s_axil_awvalid,
    input  logic [31:0]              s_axil_awaddr,
    output logic                     s_axil_awready,
    input  logic                     s_axil_wvalid,
    input  logic [31:0]              s_axil_wdata,
    output logic                     s_axil_wready,
    output logic                     s_axil_bvalid,
    output logic [1:0]               s_axil_bresp,
    input  logic                     s_axil_bready,
    input  logic                     s_axil_arvalid,
    input  logic [31:0]              s_axil_araddr,
    output logic                     s_axil_arready,
    output logic                     s_axil_rvalid,
    output logic [31:0]              s_axil_rdata,
    output logic [1:0]               s_axil_rresp,
    input  logic                     s_axil_rready,
    output logic [1:0]               mode,
    output logic [NUM_CMAC_PORT-1:0] block_rx,
    input  logic [NUM_CMAC_PORT-1:0] drop_pulse
);

    typedef enum logic [1:0] {WrIdle, WrGotAw, WrGotW, WrResp} wr_state_e;
    typedef enum logic {RdIdle, RdResp} rd_state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic [31:0]              aw_addr_q, aw_addr_d;
    logic [31:0]              w_data_q, w_data_d;
    logic [1:0]               bresp_q, bresp_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [1:0]               rresp_q, rresp_d;
    logic [1:0]               mode_q, mode_d;
    logic [NUM_CMAC_PORT-1:0] block_q, block_d;
    logic [31:0]              scratch_q, scratch_d;
    logic [31:0]              cnt_q [NUM_CMAC_PORT];
    logic [31:0]              cnt_d [NUM_CMAC_PORT];

    logic                     aw_hs, w_hs, wr_en, wr_ok;
    logic [31:0]              wr_addr, wr_data;
    logic [9:0]               wr_idx, rd_idx;
    logic [NUM_CMAC_PORT-1:0] clr;
    logic [31:0]              rd_val;
    logic [1:0]               rd_resp;
    logic                     unused_addr_bits;

    assign s_axil_awready = (wr_state_q == WrIdle) || (wr_state_q == WrGotW);
    assign s_axil_wready  = (wr_state_q == WrIdle) || (wr_state_q == WrGotAw);
    assign s_axil_bvalid  = (wr_state_q == WrResp);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = (rd_state_q == RdIdle);
    assign s_axil_rvalid  = (rd_state_q == RdResp);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign mode           = mode_q;
    assign block_rx       = block_q;

    assign aw_hs   = s_axil_awvalid && s_axil_awready;
    assign w_hs    = s_axil_wvalid && s_axil_wready;
    assign wr_idx  = wr_addr[11:2];
    assign rd_idx  = s_axil_araddr[11:2];

    // Byte-lane bits of the address carry no meaning in this map.
    assign unused_addr_bits = ^{wr_addr[1:0], s_axil_araddr[1:0]};

    // Write channel: AW and W latched independently; the update lands on the second handshake.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        wr_en      = 1'b0;
        wr_addr    = aw_addr_q;
        wr_data    = w_data_q;
        unique case (wr_state_q)
            WrIdle: begin
                if (aw_hs && w_hs) begin
                    wr_en   = 1'b1;
                    wr_addr = s_axil_awaddr;
                    wr_data = s_axil_wdata;
                end else if (aw_hs) begin
                    aw_addr_d  = s_axil_awaddr;
                    wr_state_d = WrGotAw;
                end else if (w_hs) begin
                    w_data_d   = s_axil_wdata;
                    wr_state_d = WrGotW;
                end
            end
            WrGotAw: begin
                if (w_hs) begin
                    wr_en   = 1'b1;
                    wr_data = s_axil_wdata;
                end
            end
            WrGotW: begin
                if (aw_hs) begin
                    wr_en   = 1'b1;
                    wr_addr = s_axil_awaddr;
                end
            end
            WrResp: begin
                if (s_axil_bready) begin
                    wr_state_d = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
        if (wr_en) begin
            wr_state_d = WrResp;
        end
    end

    // Register update and write response decode.
    always_comb begin
        mode_d    = mode_q;
        block_d   = block_q;
        scratch_d = scratch_q;
        bresp_d   = bresp_q;
        clr       = '0;
        wr_ok     = 1'b0;
        if (wr_en && (wr_addr[31:12] == 20'd0)) begin
            if (wr_idx == 10'd0) begin
                mode_d = wr_data[1:0];
                wr_ok  = 1'b1;
            end else if (wr_idx == 10'd1) begin
                block_d = wr_data[NUM_CMAC_PORT-1:0];
                wr_ok   = 1'b1;
            end else if (wr_idx == 10'd2) begin
                scratch_d = wr_data;
                wr_ok     = 1'b1;
            end
            for (int p = 0; p < int'(NUM_CMAC_PORT); p++) begin
                if (wr_idx == 10'(4 + p)) begin
                    clr[p] = 1'b1;
                    wr_ok  = 1'b1;
                end
            end
        end
        if (wr_en) begin
            bresp_d = wr_ok ? RespOkay : RespSlvErr;
        end
    end

    // Saturating drop counters; a same-cycle clear beats the pulse.
    always_comb begin
        for (int p = 0; p < int'(NUM_CMAC_PORT); p++) begin
            cnt_d[p] = cnt_q[p];
            if (clr[p]) begin
                cnt_d[p] = '0;
            end else if (drop_pulse[p] && (cnt_q[p] != 32'hFFFF_FFFF)) begin
                cnt_d[p] = cnt_q[p] + 32'd1;
            end
        end
    end

    always_comb begin
        rd_val  = 32'hDEAD_BEEF;
        rd_resp = RespSlvErr;
        if (s_axil_araddr[31:12] == 20'd0) begin
            if (rd_idx == 10'd0) begin
                rd_val  = {30'd0, mode_q};
                rd_resp = RespOkay;
            end else if (rd_idx == 10'd1) begin
                rd_val  = 32'(block_q);
                rd_resp = RespOkay;
            end else if (rd_idx == 10'd2) begin
                rd_val  = scratch_q;
                rd_resp = RespOkay;
            end else if (rd_idx == 10'd3) begin
                rd_val  = VERSION;
                rd_resp = RespOkay;
            end
            for (int p = 0; p < int'(NUM_CMAC_PORT); p++) begin
                if (rd_idx == 10'(4 + p)) begin
                    rd_val  = cnt_q[p];
                    rd_resp = RespOkay;
                end
            end
        end
    end

    // Read channel samples pre-write register values.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            RdIdle: begin
                if (s_axil_arvalid) begin
                    rdata_d    = rd_val;
                    rresp_d    = rd_resp;
                    rd_state_d = RdResp;
                end
            end
            RdResp: begin
                if (s_axil_rready) begin
                    rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge axil_aclk) begin
        if (axil_rst) begin
            wr_state_q <= WrIdle;
            rd_state_q <= RdIdle;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            bresp_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            mode_q     <= '0;
            block_q    <= '0;
            scratch_q  <= '0;
            for (int p = 0; p < int'(NUM_CMAC_PORT); p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            mode_q     <= mode_d;
            block_q    <= block_d;
            scratch_q  <= scratch_d;
            for (int p = 0; p < int'(NUM_CMAC_PORT); p++) begin
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

endmodule

// File: tb/tb_p2p_reg_slave.sv
// Self-checking bench for p2p_reg_slave: scoreboard queues hold expected responses,
// popped when the DUT presents bvalid/rvalid.
module tb_p2p_reg_slave;

    localparam int unsigned NP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
    logic          bready = 1'b1, rready = 1'b1;
    logic [31:0]   awaddr = '0, wdata = '0, araddr = '0;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp, mode;
    logic [31:0]   rdata;
    logic [NP-1:0] block_rx;
    logic [NP-1:0] drop_pulse = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_rd[$];
    logic [1:0]  exp_rresp[$];
    logic [1:0]  exp_bresp[$];

    always #5 clk = ~clk;

    p2p_reg_slave #(
        .NUM_CMAC_PORT(NP),
        .VERSION      (32'h0001_0000)
    ) dut (
        .axil_aclk     (clk),
        .axil_rst      (rst),
        .s_axil_awvalid(awvalid),
        .s_axil_awaddr (awaddr),
        .s_axil_awready(awready),
        .s_axil_wvalid (wvalid),
        .s_axil_wdata  (wdata),
        .s_axil_wready (wready),
        .s_axil_bvalid (bvalid),
        .s_axil_bresp  (bresp),
        .s_axil_bready (bready),
        .s_axil_arvalid(arvalid),
        .s_axil_araddr (araddr),
        .s_axil_arready(arready),
        .s_axil_rvalid (rvalid),
        .s_axil_rdata  (rdata),
        .s_axil_rresp  (rresp),
        .s_axil_rready (rready),
        .mode          (mode),
        .block_rx      (block_rx),
        .drop_pulse    (drop_pulse)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one AW+W write, returns the observed bresp and the scoreboard's expectation.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] r,
                            output logic [1:0] er, output bit ok);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        ok = 0;
        r  = 'x;
        awvalid = 1; awaddr = a; wvalid = 1; wdata = d;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step(); n++;
            if (aw_hs) begin aw_done = 1; awvalid = 0; end
            if (w_hs)  begin w_done = 1;  wvalid = 0;  end
        end
        awvalid = 0; wvalid = 0;
        while (!bvalid && n < 40) begin step(); n++; end
        if (aw_done && w_done && bvalid) begin
            ok = 1;
            r  = bresp;
            step();
        end
        er = exp_bresp.pop_front();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                           output logic [31:0] ed, output logic [1:0] er, output int lag,
                           output bit ok);
        bit hs = 0;
        int n = 0;
        ok = 0; d = 'x; r = 'x; lag = 0;
        arvalid = 1; araddr = a;
        while (!hs && n < 20) begin
            hs = arvalid && arready;
            step(); n++;
        end
        arvalid = 0;
        while (hs && !rvalid && lag < 20) begin step(); lag++; end
        if (hs && rvalid) begin
            ok = 1; d = rdata; r = rresp;
            step();
        end
        ed = exp_rd.pop_front();
        er = exp_rresp.pop_front();
    endtask

    task automatic test_reset();
        rst = 1;
        awvalid = 1; awaddr = 32'h0; wvalid = 1; wdata = 32'h1;
        arvalid = 1; araddr = 32'hC;
        repeat (3) step();
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            n_fail++;
            $display("FAIL reset_handshake: got %b want 11100",
                     {awready, wready, arready, bvalid, rvalid});
        end
        n_checks++;
        if ({mode, block_rx, bresp, rresp, rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: mode %0h block %0h bresp %0h rresp %0h rdata %0h want 0",
                     mode, block_rx, bresp, rresp, rdata);
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        rst = 0;
        step();
        n_checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || mode !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_ignored_valids: bvalid %b rvalid %b mode %0h want 0 0 0",
                     bvalid, rvalid, mode);
        end
    endtask

    task automatic test_version();
        logic [31:0] d, ed; logic [1:0] r, er; int lag; bit ok;
        exp_rd.push_back(32'h0001_0000); exp_rresp.push_back(2'b00);
        do_read(32'h0000_000C, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || lag != 0 || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL version_read: ok %0d lag %0d rdata %h rresp %b want lag 0 %h %b",
                     ok, lag, d, r, ed, er);
        end
        exp_rd.push_back(32'h0); exp_rresp.push_back(2'b00);
        do_read(32'h0000_0000, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL ctrl_reset_read: rdata %h rresp %b want %h %b", d, r, ed, er);
        end
    endtask

    task automatic test_ctrl_split();
        logic [1:0] er, r; bit ok;
        awvalid = 1; awaddr = 32'h0; wvalid = 0; bready = 1;
        exp_bresp.push_back(2'b00);
        step();
        n_checks++;
        if (awready !== 1'b0 || wready !== 1'b1 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL split_got_aw: awready %b wready %b bvalid %b want 0 1 0",
                     awready, wready, bvalid);
        end
        awvalid = 0; wvalid = 1; wdata = 32'h1;
        step();
        wvalid = 0;
        er = exp_bresp.pop_front();
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== er || mode !== 2'd1) begin
            n_fail++;
            $display("FAIL split_resp: bvalid %b bresp %b mode %0h want 1 %b 1",
                     bvalid, bresp, mode, er);
        end
        step();
        n_checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL split_next_aw: awready %b bvalid %b want 1 0", awready, bvalid);
        end
        exp_bresp.push_back(2'b00);
        do_write(32'h0, 32'h1, r, er, ok);
        n_checks++;
        if (!ok || r !== er || mode !== 2'd1) begin
            n_fail++;
            $display("FAIL split_second_write: ok %0d bresp %b mode %0h want %b 1",
                     ok, r, mode, er);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d, ed; logic [1:0] r, er; int lag; bit ok;
        awvalid = 1; awaddr = 32'h4; wvalid = 1; wdata = 32'h3;
        exp_bresp.push_back(2'b00);
        step();
        awvalid = 0; wvalid = 0;
        er = exp_bresp.pop_front();
        n_checks++;
        if (block_rx !== 2'b11 || bvalid !== 1'b1 || bresp !== er) begin
            n_fail++;
            $display("FAIL same_cycle_block: block_rx %b bvalid %b bresp %b want 11 1 %b",
                     block_rx, bvalid, bresp, er);
        end
        step();
        exp_bresp.push_back(2'b00);
        do_write(32'h8, 32'hA5A5_5A5A, r, er, ok);
        n_checks++;
        if (!ok || r !== er) begin
            n_fail++;
            $display("FAIL scratch_write: ok %0d bresp %b want %b", ok, r, er);
        end
        exp_rd.push_back(32'hA5A5_5A5A); exp_rresp.push_back(2'b00);
        do_read(32'h8, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL scratch_read: rdata %h rresp %b want %h %b", d, r, ed, er);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d, ed; logic [1:0] r, er; int lag; bit ok;
        logic [31:0] waddr [3];
        logic [31:0] raddr [8];
        waddr = '{32'h100, 32'hC, 32'h1000_0000};
        foreach (waddr[i]) begin
            exp_bresp.push_back(2'b10);
            do_write(waddr[i], 32'hFFFF_FFFF, r, er, ok);
            n_checks++;
            if (!ok || r !== er) begin
                n_fail++;
                $display("FAIL unmapped_write[%h]: bresp %b want %b", waddr[i], r, er);
            end
        end
        // Expected contents after the rejected writes: nothing may have moved.
        raddr = '{32'h100, 32'h0, 32'h4, 32'h8, 32'hC, 32'h0000_1008, 32'hB, 32'h18};
        exp_rd.push_back(32'hDEAD_BEEF); exp_rresp.push_back(2'b10);
        exp_rd.push_back(32'h1);         exp_rresp.push_back(2'b00);
        exp_rd.push_back(32'h3);         exp_rresp.push_back(2'b00);
        exp_rd.push_back(32'hA5A5_5A5A); exp_rresp.push_back(2'b00);
        exp_rd.push_back(32'h0001_0000); exp_rresp.push_back(2'b00);
        exp_rd.push_back(32'hDEAD_BEEF); exp_rresp.push_back(2'b10);
        exp_rd.push_back(32'hA5A5_5A5A); exp_rresp.push_back(2'b00);
        exp_rd.push_back(32'hDEAD_BEEF); exp_rresp.push_back(2'b10);
        foreach (raddr[i]) begin
            do_read(raddr[i], d, r, ed, er, lag, ok);
            n_checks++;
            if (!ok || d !== ed || r !== er) begin
                n_fail++;
                $display("FAIL unmapped_read[%h]: rdata %h rresp %b want %h %b",
                         raddr[i], d, r, ed, er);
            end
        end
    endtask

    task automatic test_drop();
        logic [31:0] d, ed; logic [1:0] r, er; int lag; bit ok;
        for (int i = 0; i < 3; i++) begin
            drop_pulse = 2'b10;
            step();
            drop_pulse = 2'b00;
            step();
        end
        exp_rd.push_back(32'd3); exp_rresp.push_back(2'b00);
        do_read(32'h14, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL drop1_count: rdata %h rresp %b want %h %b", d, r, ed, er);
        end
        exp_rd.push_back(32'd0); exp_rresp.push_back(2'b00);
        do_read(32'h10, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL drop0_count: rdata %h rresp %b want %h %b", d, r, ed, er);
        end
        // Clear and pulse on the same edge.
        awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h1234; drop_pulse = 2'b10;
        exp_bresp.push_back(2'b00);
        step();
        awvalid = 0; wvalid = 0; drop_pulse = 2'b00;
        er = exp_bresp.pop_front();
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== er) begin
            n_fail++;
            $display("FAIL drop_clear_resp: bvalid %b bresp %b want 1 %b", bvalid, bresp, er);
        end
        step();
        exp_rd.push_back(32'd0); exp_rresp.push_back(2'b00);
        do_read(32'h14, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL drop_clear_wins: rdata %h rresp %b want %h %b", d, r, ed, er);
        end
        drop_pulse = 2'b10;
        step();
        drop_pulse = 2'b00;
        exp_rd.push_back(32'd1); exp_rresp.push_back(2'b00);
        do_read(32'h14, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL drop_after_clear: rdata %h rresp %b want %h %b", d, r, ed, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, ed; logic [1:0] r, er, ebr; int lag; bit ok;
        awvalid = 1; awaddr = 32'h8; wvalid = 1; wdata = 32'h1234_5678;
        arvalid = 1; araddr = 32'h8;
        exp_bresp.push_back(2'b00);
        exp_rd.push_back(32'hA5A5_5A5A); exp_rresp.push_back(2'b00);
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        ebr = exp_bresp.pop_front();
        ed  = exp_rd.pop_front();
        er  = exp_rresp.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== ed || rresp !== er || bvalid !== 1'b1 || bresp !== ebr)
        begin
            n_fail++;
            $display("FAIL concurrent_rw: rvalid %b rdata %h rresp %b bvalid %b bresp %b want 1 %h %b 1 %b",
                     rvalid, rdata, rresp, bvalid, bresp, ed, er, ebr);
        end
        step();
        exp_rd.push_back(32'h1234_5678); exp_rresp.push_back(2'b00);
        do_read(32'h8, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL concurrent_after: rdata %h rresp %b want %h %b", d, r, ed, er);
        end
    endtask

    task automatic test_bready_hold_reset();
        logic [31:0] d, ed; logic [1:0] r, er; int lag; bit ok;
        bready = 0;
        awvalid = 1; awaddr = 32'h0; wvalid = 1; wdata = 32'h2;
        exp_bresp.push_back(2'b00);
        step();
        awvalid = 0; wvalid = 0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== exp_bresp[0] || awready !== 1'b0 || wready !== 1'b0
                || mode !== 2'd2) begin
                n_fail++;
                $display("FAIL bready_hold[%0d]: bvalid %b bresp %b awready %b wready %b mode %0h want 1 %b 0 0 2",
                         i, bvalid, bresp, awready, wready, mode, exp_bresp[0]);
            end
            step();
        end
        rst = 1;
        step();
        // The held response is discarded by reset.
        er = exp_bresp.pop_front();
        n_checks++;
        if (bvalid !== 1'b0 || mode !== 2'd0 || block_rx !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_hold: bvalid %b mode %0h block_rx %b want 0 0 00 (dropped bresp %b)",
                     bvalid, mode, block_rx, er);
        end
        rst = 0;
        bready = 1;
        step();
        exp_rd.push_back(32'h0); exp_rresp.push_back(2'b00);
        do_read(32'h8, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL reset_scratch: rdata %h rresp %b want %h %b", d, r, ed, er);
        end
        exp_rd.push_back(32'h0); exp_rresp.push_back(2'b00);
        do_read(32'h14, d, r, ed, er, lag, ok);
        n_checks++;
        if (!ok || d !== ed || r !== er) begin
            n_fail++;
            $display("FAIL reset_drop_cnt: rdata %h rresp %b want %h %b", d, r, ed, er);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_version();
        test_ctrl_split();
        test_same_cycle();
        test_unmapped();
        test_drop();
        test_back_to_back();
        test_bready_hold_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
